// File: rtl/vga_sync_decoder.sv
// Receive-side VGA decoder: synchronises HS/VS/RGB, measures line/frame timing, locks on and
// emits pixel coordinates and data. Define FRAME_CHKSUM_EN to add a per-frame RGB checksum.
module vga_sync_decoder #(
    parameter int unsigned CLK_PER_PIX = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_START     = 144,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_START     = 35,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned TOL         = 2,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter bit          SYNC_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [11:0] rgb_in,
    output logic        locked,
    output logic        sync_err,
    output logic        frame_start,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [11:0] pixel_rgb,
    output logic [12:0] h_period,
    output logic [12:0] h_pulse,
    output logic [10:0] v_lines
`ifdef FRAME_CHKSUM_EN
    ,
    output logic [15:0] frame_sum,
    output logic        sum_valid
`endif
);

    localparam int unsigned HNOM   = H_TOTAL * CLK_PER_PIX;
    localparam logic [12:0] HMIN   = 13'(HNOM - TOL);
    localparam logic [12:0] HMAX   = 13'(HNOM + TOL);
    localparam logic [12:0] HLOST  = 13'(2 * HNOM);
    localparam logic [12:0] HSTART = 13'(H_START * CLK_PER_PIX);
    localparam logic [12:0] HEND   = 13'((H_START + H_ACTIVE) * CLK_PER_PIX);
    localparam logic [12:0] CPP13  = 13'(CLK_PER_PIX);
    localparam logic [12:0] HMID   = 13'(CLK_PER_PIX / 2);
    localparam logic [10:0] VTOT   = 11'(V_TOTAL);
    localparam logic [10:0] VSTART = 11'(V_START);
    localparam logic [10:0] VEND   = 11'(V_START + V_ACTIVE);
    localparam logic [10:0] LMAX   = 11'(V_TOTAL + 2);
    localparam logic [3:0]  LOCKN  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

    state_e      state;
    logic [1:0]  hs_sync, vs_sync;
    logic [11:0] rgb_s1, rgb_s2;
    logic        hs_d, vs_d;
    logic [12:0] hcnt;
    logic [10:0] line;
    logic [3:0]  good_cnt;
    logic        frame_ok;

    logic        hs_n, vs_n, hs_rise, hs_fall, vs_rise;
    logic [12:0] hper, hoff;
    logic [10:0] lplus;
    logic        period_ok, hs_lost, frame_good, in_win, lock_lost;

    // Polarity-normalised syncs: 1 = pulse active
    assign hs_n       = hs_sync[1] ^ ~SYNC_POL;
    assign vs_n       = vs_sync[1] ^ ~SYNC_POL;
    assign hs_rise    = hs_n & ~hs_d;
    assign hs_fall    = ~hs_n & hs_d;
    assign vs_rise    = vs_n & ~vs_d;
    assign hper       = (hcnt == '1) ? hcnt : hcnt + 13'd1;
    assign lplus      = (line == '1) ? line : line + 11'd1;
    assign period_ok  = (hper >= HMIN) && (hper <= HMAX);
    assign hs_lost    = !hs_rise && (hcnt >= HLOST);
    assign frame_good = frame_ok && (!hs_rise || period_ok) && (lplus == VTOT);
    assign lock_lost  = hs_lost || (hs_rise && !period_ok) || (vs_rise && lplus != VTOT) ||
                        (line >= LMAX);
    assign hoff       = hcnt - HSTART;
    assign in_win     = (state == StLocked) && (hcnt >= HSTART) && (hcnt < HEND) &&
                        ((hoff % CPP13) == HMID) && (line >= VSTART) && (line < VEND);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StSearch;
            hs_sync     <= {2{~SYNC_POL}};
            vs_sync     <= {2{~SYNC_POL}};
            rgb_s1      <= '0;
            rgb_s2      <= '0;
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            hcnt        <= '0;
            line        <= '0;
            good_cnt    <= '0;
            frame_ok    <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            frame_start <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_rgb   <= '0;
            h_period    <= '0;
            h_pulse     <= '0;
            v_lines     <= '0;
        end else begin
            hs_sync <= {hs_sync[0], hs_in};
            vs_sync <= {vs_sync[0], vs_in};
            rgb_s1  <= rgb_in;
            rgb_s2  <= rgb_s1;
            hs_d    <= hs_n;
            vs_d    <= vs_n;

            if (hs_rise) hcnt <= '0;
            else if (hcnt != '1) hcnt <= hcnt + 13'd1;

            // VS clear takes priority over a coincident HS increment
            if (vs_rise) line <= '0;
            else if (hs_rise && line != '1) line <= line + 11'd1;

            if (hs_rise) h_period <= hper;
            if (hs_fall) h_pulse <= hper;
            if (vs_rise) v_lines <= lplus;

            frame_start <= 1'b0;
            pixel_valid <= 1'b0;
            if (in_win) begin
                pixel_valid <= 1'b1;
                pixel_x     <= 10'(hoff / CPP13);
                pixel_y     <= 10'(line - VSTART);
                pixel_rgb   <= rgb_s2;
            end

            if (hs_rise && !period_ok) frame_ok <= 1'b0;

            unique case (state)
                StSearch: begin
                    if (vs_rise) begin
                        state    <= StMeasure;
                        good_cnt <= '0;
                        frame_ok <= 1'b1;
                    end
                end
                StMeasure: begin
                    if (hs_lost) begin
                        state <= StSearch;
                    end else if (vs_rise) begin
                        frame_ok <= 1'b1;
                        if (!frame_good) begin
                            good_cnt <= '0;
                        end else if (good_cnt + 4'd1 >= LOCKN) begin
                            state    <= StLocked;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                        end
                    end
                end
                StLocked: begin
                    if (lock_lost) begin
                        state    <= StSearch;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                    end else if (vs_rise) begin
                        frame_start <= 1'b1;
                    end
                end
                default: begin
                    state  <= StSearch;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_CHKSUM_EN
    logic [15:0] acc;

    always_ff @(posedge clk) begin
        if (reset || state != StLocked) begin
            acc       <= '0;
            frame_sum <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (vs_rise) begin
                frame_sum <= acc;
                sum_valid <= 1'b1;
                acc       <= '0;
            end else if (pixel_valid) begin
                acc <= acc + 16'(pixel_rgb);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (20x12 px, 4 clk/px) so many frames fit.
// Expected pixels are queued as driven; a monitor pops and compares on every pixel_valid.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

    localparam int CPP = 4;
    localparam int HT  = 20;
    localparam int HST = 6;
    localparam int HA  = 10;
    localparam int VT  = 12;
    localparam int VST = 3;
    localparam int VA  = 6;
    localparam int HPW = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic        locked, sync_err, frame_start, pixel_valid;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] pixel_rgb;
    logic [12:0] h_period, h_pulse;
    logic [10:0] v_lines;
`ifdef FRAME_CHKSUM_EN
    logic [15:0] frame_sum;
    logic        sum_valid;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .CLK_PER_PIX(CPP), .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA), .TOL(2), .LOCK_FRAMES(2), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in), .rgb_in(rgb_in),
        .locked(locked), .sync_err(sync_err), .frame_start(frame_start),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_rgb(pixel_rgb), .h_period(h_period), .h_pulse(h_pulse), .v_lines(v_lines)
`ifdef FRAME_CHKSUM_EN
        , .frame_sum(frame_sum), .sum_valid(sum_valid)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {28'd0, locked, sync_err, frame_start, pixel_valid}, 32'd0);
        check({tag, "_x"}, {22'd0, pixel_x}, 32'd0);
        check({tag, "_y"}, {22'd0, pixel_y}, 32'd0);
        check({tag, "_rgb"}, {20'd0, pixel_rgb}, 32'd0);
        check({tag, "_h_period"}, {19'd0, h_period}, 32'd0);
        check({tag, "_h_pulse"}, {19'd0, h_pulse}, 32'd0);
        check({tag, "_v_lines"}, {21'd0, v_lines}, 32'd0);
    endtask

    // Monitor: every strobe must match the oldest queued pixel
    always @(negedge clk) begin
        if (pixel_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got x=%0d y=%0d rgb=%0h, required no strobe",
                         pixel_x, pixel_y, pixel_rgb);
            end else begin
                check("pixel", {pixel_x, pixel_y, pixel_rgb}, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_zero("in_reset");
        end
        reset = 1'b0;
        @(negedge clk);
        check_zero("after_reset");
    endtask

    task automatic drive_line(input int f, input int l, input int len, input bit lk);
        logic [9:0] x, y;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (f == 2 && l == 0 && c == 2) check("lock_not_early", {31'd0, locked}, 32'd0);
            if (f == 2 && l == 0 && c == 3) begin
                check("lock_rise", {31'd0, locked}, 32'd1);
                check("no_fs_on_lock", {31'd0, frame_start}, 32'd0);
            end
            if (f == 2 && l == 1 && c == 0) begin
                check("h_period", {19'd0, h_period}, 32'd80);
                check("h_pulse", {19'd0, h_pulse}, 32'd12);
                check("v_lines", {21'd0, v_lines}, 32'd12);
                check("sync_err_clean", {31'd0, sync_err}, 32'd0);
            end
            if (f == 3 && l == 0 && c == 3) begin
                check("frame_start", {31'd0, frame_start}, 32'd1);
`ifdef FRAME_CHKSUM_EN
                check("sum_valid", {31'd0, sum_valid}, 32'd1);
                check("frame_sum", {16'd0, frame_sum}, 32'd6584);
`endif
            end
            if (f == 3 && l == 0 && c == 4) check("fs_one_cycle", {31'd0, frame_start}, 32'd0);
            if (f == 4 && l == 6 && c == 2) check("lock_before_bad", {31'd0, locked}, 32'd1);
            if (f == 4 && l == 6 && c == 3) begin
                check("unlock_bad_period", {31'd0, locked}, 32'd0);
                check("sync_err_set", {31'd0, sync_err}, 32'd1);
                check("h_period_long", {19'd0, h_period}, 32'd85);
            end
            if (f == 7 && l == 0 && c == 3) begin
                check("relock", {31'd0, locked}, 32'd1);
                check("sync_err_sticky", {31'd0, sync_err}, 32'd1);
            end
`ifdef FRAME_CHKSUM_EN
            if (f == 8 && l == 0 && c == 3) check("frame_sum_relock", {16'd0, frame_sum}, 32'd6584);
`endif
            if (f == 8 && l == 4 && c == 163) check("hs_lost_early", {31'd0, locked}, 32'd1);
            if (f == 8 && l == 4 && c == 164) check("hs_lost", {31'd0, locked}, 32'd0);
            if (f == 14 && l == 0 && c == 3) begin
                check("lock_post_reset", {31'd0, locked}, 32'd1);
                check("sync_err_post_reset", {31'd0, sync_err}, 32'd0);
            end

            hs_in = (c < HPW * CPP);
            vs_in = (l < 2);
            if (c / CPP >= HST && c / CPP < HST + HA && l >= VST && l < VST + VA) begin
                x      = 10'(c / CPP - HST);
                y      = 10'(l - VST);
                rgb_in = {x[3:0], y[3:0], 4'hA};
                if (lk && (c % CPP) == 0) exp_q.push_back({x, y, rgb_in});
            end else begin
                rgb_in = '0;
            end
            if (f == 11 && l == 10 && c == 40) do_reset();
        end
    endtask

    initial begin
        int len;
        bit lk;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        for (int f = 0; f < 15; f++) begin
            for (int l = 0; l < VT; l++) begin
                len = HT * CPP;
                if (f == 4 && l == 5) len = HT * CPP + 5;
                if (f == 8 && l == 4) len = HT * CPP + 200;
                lk = (f == 2) || (f == 3) || (f == 4 && l <= 5) || (f == 7) ||
                     (f == 8 && l <= 4) || (f == 11) || (f == 14);
                drive_line(f, l, len, lk);
            end
        end
        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("locked_at_end", {31'd0, locked}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
